async_fifo_rptr_ctrl: RTL and testbench

//  Read-side pointer controller for the dual-clock FIFO in cbb.

---
 rtl/async_fifo_rptr_ctrl.sv | 114 +++++++++++
 tb/tb_async_fifo_rptr_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rptr_ctrl.sv
// -----------------------------------------------------------------------------
// async_fifo_rptr_ctrl
//   Read-side pointer controller of a dual-clock FIFO. Brings the write
//   domain's Gray write pointer into clk through a flop chain, converts it to
//   binary, keeps the read pointer (binary for addressing, Gray for the trip
//   back to the write domain) and derives empty / almost_empty / fill level.
//
// Ports
//   clk          in   read-domain clock
//   rst_n        in   asynchronous active-low reset (released synchronously upstream)
//   wptr_gray    in   [ADDR_W:0]   write pointer, Gray, asynchronous to clk
//   rd_req       in   consumer read request
//   rd_ack       out  read accepted this cycle (rd_req & ~empty), combinational
//   rd_addr      out  [ADDR_W-1:0] RAM read address
//   rptr_gray    out  [ADDR_W:0]   registered Gray read pointer
//   empty        out  registered FIFO empty flag
//   almost_empty out  registered, rd_level <= AE_THRESH
//   rd_level     out  [ADDR_W:0]   registered number of readable entries
// -----------------------------------------------------------------------------
module async_fifo_rptr_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level
);

  localparam int PTR_W = ADDR_W + 1;

  // Write-pointer synchroniser chain; only the last stage is used.
  logic [PTR_W-1:0] sync_reg [SYNC_STAGES];
  logic [PTR_W-1:0] wsync;
  logic [PTR_W-1:0] wbin;

  logic [PTR_W-1:0] rptr_bin_reg;
  logic [PTR_W-1:0] rptr_bin_next;
  logic [PTR_W-1:0] rptr_gray_reg;
  logic [PTR_W-1:0] rptr_gray_next;
  logic [PTR_W-1:0] level_reg;
  logic [PTR_W-1:0] level_next;
  logic             empty_reg;
  logic             empty_next;
  logic             ae_reg;
  logic             ae_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign wsync = sync_reg[SYNC_STAGES-1];

  // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PTR_W; gi++) begin : g_gray2bin
      assign wbin[gi] = ^(wsync >> gi);
    end
  endgenerate

  // A read is only accepted against the registered empty flag, so a held
  // rd_req can never step the pointer past the last synchronised entry.
  assign rd_ack = rd_req & ~empty_reg;

  always_comb begin
    rptr_bin_next  = rptr_bin_reg + {{ADDR_W{1'b0}}, rd_ack};
    rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1);
    // Raw modulo difference; a well-behaved writer keeps it <= 2**ADDR_W.
    level_next     = wbin - rptr_bin_next;
    // Comparing Gray codes directly keeps empty off the conversion path.
    empty_next     = (rptr_gray_next == wsync);
    ae_next        = (level_next <= PTR_W'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_bin_reg  <= '0;
      rptr_gray_reg <= '0;
      level_reg     <= '0;
      empty_reg     <= 1'b1;
      ae_reg        <= 1'b1;
    end else begin
      rptr_bin_reg  <= rptr_bin_next;
      rptr_gray_reg <= rptr_gray_next;
      level_reg     <= level_next;
      empty_reg     <= empty_next;
      ae_reg        <= ae_next;
    end
  end

  assign rd_addr      = rptr_bin_reg[ADDR_W-1:0];
  assign rptr_gray    = rptr_gray_reg;
  assign empty        = empty_reg;
  assign almost_empty = ae_reg;
  assign rd_level     = level_reg;

endmodule

// File: tb/tb_async_fifo_rptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_rptr_ctrl
//   Self-checking bench for async_fifo_rptr_ctrl (ADDR_W=4, SYNC_STAGES=2,
//   AE_THRESH=1). The reference model counts entries with plain integer
//   arithmetic: the reader position, and the writer position as seen
//   SYNC_STAGES edges late.
// -----------------------------------------------------------------------------
module tb_async_fifo_rptr_ctrl;

  localparam int AW  = 4;
  localparam int SS  = 2;
  localparam int AE  = 1;
  localparam int MOD = 32;
  localparam int DEP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  wptr_gray = '0;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [3:0]  rd_addr;
  logic [4:0]  rptr_gray;
  logic        empty;
  logic        almost_empty;
  logic [4:0]  rd_level;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int w_bin = 0;          // writer position (what the write side has produced)
  int rptr_m = 0;         // entries consumed, mod 32
  int level_m = 0;
  bit empty_m = 1'b1;
  int hist [SS];          // writer positions seen at the last SS edges

  always #5 clk = ~clk;

  async_fifo_rptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wptr_gray(wptr_gray), .rd_req(rd_req),
    .rd_ack(rd_ack), .rd_addr(rd_addr), .rptr_gray(rptr_gray), .empty(empty),
    .almost_empty(almost_empty), .rd_level(rd_level)
  );

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  // Advance one clock and the model with it; returns at posedge + 1.
  task automatic tick();
    bit ack;
    int wd;
    wptr_gray = to_gray(w_bin);
    ack = rd_req && !empty_m;
    @(posedge clk);
    if (rst_n) begin
      wd = hist[SS-1];
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = w_bin;
      rptr_m  = (rptr_m + int'(ack)) % MOD;
      level_m = (wd - rptr_m + MOD) % MOD;
      empty_m = (level_m == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    rd_req = 1'b1;
    rst_n  = 1'b0;
    #1;
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
    vectors++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %0b want 1", almost_empty); end
    vectors++; if (rd_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", rd_level); end
    vectors++; if (rptr_gray !== 5'd0) begin errors++; $display("FAIL reset_rptr_gray: got %b want 00000", rptr_gray); end
    vectors++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    vectors++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %0b want 0", rd_ack); end
    w_bin = 0; rptr_m = 0; level_m = 0; empty_m = 1'b1;
    for (int i = 0; i < SS; i++) hist[i] = 0;
    rd_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_entry();
    w_bin = 1;
    rd_req = 1'b0;
    tick();
    tick();
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL single_early_empty: got %0b want 1 after edge 2", empty); end
    tick();
    vectors++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %0b want 0 after edge 3", empty); end
    vectors++; if (rd_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d want 1", rd_level); end
    rd_req = 1'b1;
    #1;
    vectors++; if (rd_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %0b want 1", rd_ack); end
    vectors++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", rd_addr); end
    tick();
    rd_req = 1'b0;
    vectors++; if (rptr_gray !== 5'b00001) begin errors++; $display("FAIL single_rptr_gray: got %b want 00001", rptr_gray); end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %0b want 1", empty); end
    vectors++; if (rd_level !== 5'd0) begin errors++; $display("FAIL single_level_after: got %0d want 0", rd_level); end
  endtask

  task automatic test_read_on_empty();
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL empty_read_ack[%0d]: got %0b want 0", i, rd_ack); end
      tick();
      vectors++; if (rptr_gray !== 5'b00001 || rd_addr !== 4'd1) begin
        errors++; $display("FAIL empty_read_ptr[%0d]: got gray %b addr %0d want 00001 / 1", i, rptr_gray, rd_addr);
      end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_full_drain();
    w_bin = DEP;
    rd_req = 1'b0;
    tick(); tick(); tick();
    vectors++; if (rd_level !== 5'd16) begin errors++; $display("FAIL drain_level: got %0d want 16", rd_level); end
    vectors++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL drain_ae: got %0b want 0", almost_empty); end
    rd_req = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      #1;
      vectors++; if (rd_ack !== 1'b1 || rd_addr !== 4'(i)) begin
        errors++; $display("FAIL drain_accept[%0d]: got ack %0b addr %0d want 1 / %0d", i, rd_ack, rd_addr, i);
      end
      tick();
    end
    vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b want 1", empty); end
    vectors++; if (rptr_gray !== 5'b11000) begin errors++; $display("FAIL drain_rptr_gray: got %b want 11000", rptr_gray); end
    #1;
    vectors++; if (rd_ack !== 1'b0) begin errors++; $display("FAIL drain_overread: got %0b want 0", rd_ack); end
    rd_req = 1'b0;
  endtask

  task automatic test_wrap();
    // Move the read pointer to 30 first
    w_bin = 30;
    rd_req = 1'b0;
    tick(); tick(); tick();
    rd_req = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    rd_req = 1'b0;
    vectors++; if (rptr_gray !== 5'b10001 || rd_addr !== 4'd14 || empty !== 1'b1) begin
      errors++; $display("FAIL wrap_start: got gray %b addr %0d empty %0b want 10001 / 14 / 1", rptr_gray, rd_addr, empty);
    end
    w_bin = 31; tick();
    w_bin = 0;  tick(); tick(); tick();
    vectors++; if (rd_level !== 5'd2) begin errors++; $display("FAIL wrap_level: got %0d want 2", rd_level); end
    rd_req = 1'b1;
    #1;
    vectors++; if (rd_ack !== 1'b1 || rd_addr !== 4'd14) begin
      errors++; $display("FAIL wrap_read0: got ack %0b addr %0d want 1 / 14", rd_ack, rd_addr);
    end
    tick();
    vectors++; if (rptr_gray !== 5'b10000 || rd_level !== 5'd1) begin
      errors++; $display("FAIL wrap_mid: got gray %b level %0d want 10000 / 1", rptr_gray, rd_level);
    end
    vectors++; if (rd_ack !== 1'b1 || rd_addr !== 4'd15) begin
      errors++; $display("FAIL wrap_read1: got ack %0b addr %0d want 1 / 15", rd_ack, rd_addr);
    end
    tick();
    vectors++; if (rptr_gray !== 5'b00000 || empty !== 1'b1 || rd_level !== 5'd0) begin
      errors++; $display("FAIL wrap_end: got gray %b empty %0b level %0d want 00000 / 1 / 0", rptr_gray, empty, rd_level);
    end
    rd_req = 1'b0;
    w_bin = 1;
    tick(); tick(); tick();
    rd_req = 1'b1;
    #1;
    vectors++; if (rd_ack !== 1'b1 || rd_addr !== 4'd0) begin
      errors++; $display("FAIL wrap_after: got ack %0b addr %0d want 1 / 0", rd_ack, rd_addr);
    end
    tick();
    rd_req = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] prev_gray;
    int exp_lvl;
    for (int n = 0; n < 10000; n++) begin
      if (((w_bin - rptr_m + MOD) % MOD) < DEP && $urandom_range(0, 1) == 1)
        w_bin = (w_bin + 1) % MOD;
      rd_req = ($urandom_range(0, 9) < 6);
      #1;
      vectors++; if (rd_ack !== (rd_req && !empty_m)) begin
        errors++; $display("FAIL rand_ack[%0d]: got %0b want %0b", n, rd_ack, rd_req && !empty_m);
      end
      prev_gray = rptr_gray;
      tick();
      exp_lvl = level_m;
      vectors++;
      if (rd_level !== 5'(exp_lvl) || empty !== empty_m || almost_empty !== (exp_lvl <= AE)
          || rptr_gray !== to_gray(rptr_m) || rd_addr !== 4'(rptr_m % DEP)) begin
        errors++;
        $display("FAIL rand_state[%0d]: got lvl %0d emp %0b ae %0b gray %b addr %0d want %0d %0b %0b %b %0d",
                 n, rd_level, empty, almost_empty, rptr_gray, rd_addr,
                 exp_lvl, empty_m, exp_lvl <= AE, to_gray(rptr_m), rptr_m % DEP);
      end
      vectors++; if ($countones(rptr_gray ^ prev_gray) > 1) begin
        errors++; $display("FAIL rand_gray_step[%0d]: got %b -> %b want <=1 bit change", n, prev_gray, rptr_gray);
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < SS; i++) hist[i] = 0;
    #2;
    test_reset();
    test_single_entry();
    test_read_on_empty();
    test_reset();
    test_full_drain();
    test_wrap();
    test_random();
    // Reset again with the FIFO mid-stream and rd_req held high
    w_bin = (w_bin + 3) % MOD;
    tick(); tick(); tick();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
